// File: rtl/tlb_pkg.sv
// Shared TLB definitions: entry geometry defaults,
// value field layout and the flush sequencer states.
package tlb_pkg;

  localparam int TLB_ENTRY_COUNT   = 32;
  localparam int TLB_FIXED_ENTRIES = 4;

  localparam int TLB_PFN_WIDTH   = 20;
  localparam int TLB_PFN_LSB     = 1;
  localparam int TLB_WBIT_POS    = 0;
  localparam int TLB_VALUE_WIDTH = TLB_PFN_WIDTH + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  function automatic logic [TLB_VALUE_WIDTH-1:0] tlb_pack(
    input logic [TLB_PFN_WIDTH-1:0] pfn,
    input logic                     wbit
  );
    logic [TLB_VALUE_WIDTH-1:0] v;
    v = '0;
    v[TLB_PFN_LSB +: TLB_PFN_WIDTH] = pfn;
    v[TLB_WBIT_POS] = wbit;
    return v;
  endfunction

endpackage

// File: rtl/tlb_entry_store_ram.sv
// Dual-port synchronous RAM: port 1 read-only, port 2
// write-first read/write. No reset; block-RAM inferable.
module tlb_dual_port_ram #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 21,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] rw_index,
  input  logic                  rw_we,
  input  logic [DATA_WIDTH-1:0] rw_wdata,
  output logic [DATA_WIDTH-1:0] rw_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rw_rdata_q;

  // Port 1 sees the pre-write contents on a same-index write.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_index];
    if (rw_we) begin
      mem_q[rw_index] <= rw_wdata;
      rw_rdata_q      <= rw_wdata;
    end else begin
      rw_rdata_q <= mem_q[rw_index];
    end
  end

  assign rd_data  = rd_data_q;
  assign rw_rdata = rw_rdata_q;

endmodule

// File: rtl/tlb_entry_store.sv
// TLB value store: RAM-held values, flop valid bits,
// flush sequencer and random replacement index.
// Ports: lookup (read-only), management (write-first rd/wr,
// invalidate), flushRequest/busy, randomIndex.
module tlb_entry_store
  import tlb_pkg::*;
#(
  parameter int ENTRY_COUNT   = TLB_ENTRY_COUNT,
  parameter int VALUE_WIDTH   = TLB_VALUE_WIDTH,
  parameter int FIXED_ENTRIES = TLB_FIXED_ENTRIES,
  localparam int INDEX_WIDTH  = $clog2(ENTRY_COUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] lookupIndex,
  output logic [VALUE_WIDTH-1:0] lookupData,
  output logic                   lookupValid,
  input  logic [INDEX_WIDTH-1:0] mgmtIndex,
  input  logic                   mgmtWriteEnable,
  input  logic [VALUE_WIDTH-1:0] mgmtWriteData,
  input  logic                   mgmtInvalidate,
  output logic [VALUE_WIDTH-1:0] mgmtReadData,
  output logic                   mgmtReadValid,
  input  logic                   flushRequest,
  output logic                   busy,
  output logic [INDEX_WIDTH-1:0] randomIndex
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX =
    INDEX_WIDTH'(ENTRY_COUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] FIXED_IDX =
    INDEX_WIDTH'(FIXED_ENTRIES);

  flush_state_e state_q, state_d;

  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [INDEX_WIDTH-1:0] rand_q, rand_d;
  logic [ENTRY_COUNT-1:0] valid_q, valid_d;

  logic                   lk_valid_q, lk_valid_d;
  logic                   lk_live_q, lk_live_d;
  logic                   mr_valid_q, mr_valid_d;
  logic                   mr_sel_q, mr_sel_d;
  logic [VALUE_WIDTH-1:0] mr_hold_q, mr_hold_d;

  logic                   idle;
  logic                   flush_start;

  logic [VALUE_WIDTH-1:0] ram_lk_data;
  logic [INDEX_WIDTH-1:0] ram_rw_index;
  logic                   ram_rw_we;
  logic [VALUE_WIDTH-1:0] ram_rw_wdata;
  logic [VALUE_WIDTH-1:0] ram_rw_rdata;

  assign idle        = (state_q == ST_IDLE);
  assign flush_start = idle & flushRequest;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flushRequest) begin
          state_d = ST_FLUSH;
          sweep_d = '0;
        end
      end
      ST_FLUSH: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Port 2 belongs to the sweep while flushing.
  always_comb begin
    ram_rw_index = mgmtIndex;
    ram_rw_we    = mgmtWriteEnable;
    ram_rw_wdata = mgmtWriteData;
    if (!idle) begin
      ram_rw_index = sweep_q;
      ram_rw_we    = 1'b1;
      ram_rw_wdata = '0;
    end
  end

  // Write is applied after invalidate so it wins.
  always_comb begin
    valid_d = valid_q;
    if (flush_start) begin
      valid_d = '0;
    end else if (idle) begin
      if (mgmtInvalidate) begin
        valid_d[mgmtIndex] = 1'b0;
      end
      if (mgmtWriteEnable) begin
        valid_d[mgmtIndex] = 1'b1;
      end
    end
  end

  always_comb begin
    lk_live_d  = 1'b1;
    lk_valid_d = valid_q[lookupIndex] & ~flush_start;
    mr_valid_d = idle ? valid_d[mgmtIndex] : mr_valid_q;
    mr_sel_d   = idle;
    // Capture the last management read before the sweep
    // takes over port 2, so the output holds while busy.
    mr_hold_d  = mr_sel_q ? ram_rw_rdata : mr_hold_q;
    rand_d     = (rand_q == FIXED_IDX) ? LAST_IDX
                                       : rand_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sweep_q    <= '0;
      rand_q     <= LAST_IDX;
      valid_q    <= '0;
      lk_valid_q <= 1'b0;
      lk_live_q  <= 1'b0;
      mr_valid_q <= 1'b0;
      mr_sel_q   <= 1'b0;
      mr_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      rand_q     <= rand_d;
      valid_q    <= valid_d;
      lk_valid_q <= lk_valid_d;
      lk_live_q  <= lk_live_d;
      mr_valid_q <= mr_valid_d;
      mr_sel_q   <= mr_sel_d;
      mr_hold_q  <= mr_hold_d;
    end
  end

  tlb_dual_port_ram #(
    .DEPTH      (ENTRY_COUNT),
    .DATA_WIDTH (VALUE_WIDTH)
  ) u_ram (
    .clk      (clock),
    .rd_index (lookupIndex),
    .rd_data  (ram_lk_data),
    .rw_index (ram_rw_index),
    .rw_we    (ram_rw_we),
    .rw_wdata (ram_rw_wdata),
    .rw_rdata (ram_rw_rdata)
  );

  // RAM output regs have no reset; mask until first read.
  assign lookupData    = lk_live_q ? ram_lk_data : '0;
  assign lookupValid   = lk_valid_q;
  assign mgmtReadData  = mr_sel_q ? ram_rw_rdata : mr_hold_q;
  assign mgmtReadValid = mr_valid_q;
  assign busy          = ~idle;
  assign randomIndex   = rand_q;

endmodule
